// File: rtl/servant_uart_pkg.sv
// Shared constants for the servant UART blocks: FSM encodings, status bit
// positions and the clear-overflow command bit.
package servant_uart_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam int STAT_BUSY   = 0;
  localparam int STAT_FULL   = 1;
  localparam int STAT_OVF    = 2;
  localparam int CLR_OVF_BIT = 8;

  function automatic logic [31:0] pack_status(input logic busy, input logic full,
                                              input logic ovf);
    logic [31:0] s;
    s            = '0;
    s[STAT_BUSY] = busy;
    s[STAT_FULL] = full;
    s[STAT_OVF]  = ovf;
    return s;
  endfunction

endpackage

// File: rtl/servant_fifo.sv
// Byte-wide synchronous FIFO, depth 2**AW. A pop frees a slot in the same
// cycle, so a push into a full FIFO is accepted when a pop happens alongside.
module servant_fifo #(
  parameter int AW = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] din_i,
  output logic [7:0] dout_o,
  output logic       full_o,
  output logic       empty_o
);

  logic [7:0]  mem_q [2**AW];
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rptr_q[AW-1:0]];

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/servant_uart_tx.sv
// Buffered 8N1 UART transmitter on a one-address Wishbone slot: writes fill a
// FIFO, a baud-rate FSM drains it LSB first, reads return a status word.
module servant_uart_tx
  import servant_uart_pkg::*;
#(
  parameter int DIV     = 139,
  parameter int FIFO_AW = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wb_cyc,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_dat,
  output logic [31:0] o_wb_rdt,
  output logic        o_tx,
  output logic        o_busy
);

  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] BAUD_RELOAD = CNT_W'(DIV - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             ovf_q, ovf_d;

  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_dout;
  logic       wr, clr_cmd, baud_end;
  logic       unused_dat;

  assign wr         = i_wb_cyc && i_wb_we;
  assign clr_cmd    = wr && i_wb_dat[CLR_OVF_BIT];
  assign fifo_push  = wr && !i_wb_dat[CLR_OVF_BIT];
  assign baud_end   = (baud_q == '0);
  assign unused_dat = ^i_wb_dat[31:9];

  servant_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   (i_wb_dat[7:0]),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          baud_d   = BAUD_RELOAD;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (baud_end) begin
          baud_d  = BAUD_RELOAD;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          baud_d  = BAUD_RELOAD;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = ST_STOP;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_end) begin
          // Chain straight into the next start bit so queued bytes leave with no idle gap.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            baud_d   = BAUD_RELOAD;
            state_d  = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A push into a full FIFO still lands when the FSM pops in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (clr_cmd)                                ovf_d = 1'b0;
    else if (fifo_push && fifo_full && !fifo_pop) ovf_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    o_tx = 1'b1;
    if (state_q == ST_START)     o_tx = 1'b0;
    else if (state_q == ST_DATA) o_tx = shift_q[0];
  end

  assign o_busy   = (state_q != ST_IDLE) || !fifo_empty;
  assign o_wb_rdt = pack_status(o_busy, fifo_full, ovf_q);

endmodule
